// File: rtl/framer_pkg.sv
// Shared definitions for the local packet framer: FSM state encoding,
// fixed K-character words and the CRC-16 constants.
// Build option: LOCAL_PACKET_FRAMER_CRC_EN adds the CRC state to the enum.
package framer_pkg;

`ifdef LOCAL_PACKET_FRAMER_CRC_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOF  = 2'd1,
        DATA = 2'd2,
        CRC  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOF  = 2'd1,
        DATA = 2'd2
    } state_t;
`endif

    // K28.5 in the low byte, D16.2 in the high byte
    localparam logic [15:0] IDLE_WORD = 16'h50BC;
    localparam logic [1:0]  IDLE_K    = 2'b01;
    // K28.1 marks start of frame; node number rides in the high byte
    localparam logic [7:0]  SOF_K     = 8'h3C;
    localparam logic [1:0]  SOF_KFLAG = 2'b01;
    localparam logic [1:0]  DATA_K    = 2'b00;

    localparam logic [15:0] CRC_POLY  = 16'h1021;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;

endpackage

// File: rtl/crc16_word.sv
// Combinational CRC-16 (poly 0x1021, non-reflected) advance by one
// 16-bit word, MSB of the word shifted in first.
module crc16_word
    import framer_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o
);

    logic [15:0] acc;

    // Bit-serial LFSR unrolled over the 16 data bits
    always_comb begin
        acc = crc_i;
        for (int i = 15; i >= 0; i--) begin
            if (acc[15] ^ data_i[i]) begin
                acc = (acc << 1) ^ CRC_POLY;
            end else begin
                acc = acc << 1;
            end
        end
        crc_o = acc;
    end

endmodule

// File: rtl/local_packet_framer.sv
// Local packet framer: captures a payload on each txToggle change into a
// one-entry hold buffer and serialises it as SOF word, DATA_WIDTH/16 data
// words (MS first) and, optionally, a CRC-16 word, idling with K28.5/D16.2.
// Build option: LOCAL_PACKET_FRAMER_CRC_EN enables the CRC state and logic.
//
// state | meaning
// IDLE  | sending idle words, waiting for a pending payload
// SOF   | sending {nodeId, K28.1}
// DATA  | sending payload words, index 0 .. DATA_WIDTH/16-1
// CRC   | sending CRC-16 over the data words (CRC builds only)
module local_packet_framer
    import framer_pkg::*;
#(
    parameter int DATA_WIDTH = 160,
    parameter     DEBUG      = "false"
) (
    (* mark_debug = DEBUG *) input  logic                  clk,
    (* mark_debug = DEBUG *) input  logic                  rstN,
    (* mark_debug = DEBUG *) input  logic                  txToggle,
    (* mark_debug = DEBUG *) input  logic [DATA_WIDTH-1:0] localData,
    (* mark_debug = DEBUG *) input  logic [7:0]            nodeId,
    (* mark_debug = DEBUG *) input  logic                  txReady,
    (* mark_debug = DEBUG *) output logic [15:0]           txWord,
    (* mark_debug = DEBUG *) output logic [1:0]            txCharIsK,
    (* mark_debug = DEBUG *) output logic [15:0]           overrunCount,
    (* mark_debug = DEBUG *) output logic                  busy
);

    localparam int NW    = DATA_WIDTH / 16;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    state_t                  state_q, state_d;
    logic                    tog_q;
    logic                    detect;
    logic                    unload;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    pending_q, pending_d;
    logic [15:0]             ovr_q, ovr_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d, shift_adv;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [15:0]             word_q, word_d;
    logic [1:0]              k_q, k_d;
    logic                    busy_q, busy_d;

`ifdef LOCAL_PACKET_FRAMER_CRC_EN
    logic [15:0]             crc_q, crc_d;
    logic [15:0]             crc_seed, crc_data, crc_next;
`endif

    assign detect    = txToggle ^ tog_q;
    assign shift_adv = shift_q << 16;

    // Toggle copy runs free, including during reset, so release never
    // sees a stale edge
    always_ff @(posedge clk) begin
        tog_q <= txToggle;
    end

`ifdef LOCAL_PACKET_FRAMER_CRC_EN
    // The CRC always advances with the word about to be presented:
    // word 0 when leaving SOF, the next shifted word while in DATA
    assign crc_seed = (state_q == SOF) ? CRC_INIT : crc_q;
    assign crc_data = (state_q == SOF) ? shift_q[DATA_WIDTH-1 -: 16]
                                       : shift_adv[DATA_WIDTH-1 -: 16];

    crc16_word u_crc (
        .crc_i  (crc_seed),
        .data_i (crc_data),
        .crc_o  (crc_next)
    );
`endif

    // Next state and next registered output word, advancing only on txReady
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        word_d  = word_q;
        k_d     = k_q;
        busy_d  = busy_q;
        unload  = 1'b0;
`ifdef LOCAL_PACKET_FRAMER_CRC_EN
        crc_d   = crc_q;
`endif
        if (txReady) begin
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_d = SOF;
                        shift_d = hold_q;
                        word_d  = {nodeId, SOF_K};
                        k_d     = SOF_KFLAG;
                        busy_d  = 1'b1;
                        unload  = 1'b1;
                    end else begin
                        word_d  = IDLE_WORD;
                        k_d     = IDLE_K;
                        busy_d  = 1'b0;
                    end
                end
                SOF: begin
                    state_d = DATA;
                    idx_d   = '0;
                    word_d  = shift_q[DATA_WIDTH-1 -: 16];
                    k_d     = DATA_K;
`ifdef LOCAL_PACKET_FRAMER_CRC_EN
                    crc_d   = crc_next;
`endif
                end
                DATA: begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_adv;
                        word_d  = shift_adv[DATA_WIDTH-1 -: 16];
                        k_d     = DATA_K;
`ifdef LOCAL_PACKET_FRAMER_CRC_EN
                        crc_d   = crc_next;
`endif
                    end else begin
                        idx_d = '0;
`ifdef LOCAL_PACKET_FRAMER_CRC_EN
                        state_d = CRC;
                        word_d  = crc_q;
                        k_d     = DATA_K;
`else
                        if (pending_q) begin
                            state_d = SOF;
                            shift_d = hold_q;
                            word_d  = {nodeId, SOF_K};
                            k_d     = SOF_KFLAG;
                            busy_d  = 1'b1;
                            unload  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            word_d  = IDLE_WORD;
                            k_d     = IDLE_K;
                            busy_d  = 1'b0;
                        end
`endif
                    end
                end
`ifdef LOCAL_PACKET_FRAMER_CRC_EN
                CRC: begin
                    if (pending_q) begin
                        state_d = SOF;
                        shift_d = hold_q;
                        word_d  = {nodeId, SOF_K};
                        k_d     = SOF_KFLAG;
                        busy_d  = 1'b1;
                        unload  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        word_d  = IDLE_WORD;
                        k_d     = IDLE_K;
                        busy_d  = 1'b0;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    word_d  = IDLE_WORD;
                    k_d     = IDLE_K;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Hold buffer: a detection refills it unless a payload is still waiting;
    // an unload on the same edge frees the slot, so that is not an overrun
    always_comb begin
        hold_d    = hold_q;
        pending_d = pending_q;
        ovr_d     = ovr_q;
        if (unload) begin
            pending_d = 1'b0;
        end
        if (detect) begin
            if (pending_q && !unload) begin
                if (ovr_q != 16'hFFFF) begin
                    ovr_d = ovr_q + 16'd1;
                end
            end else begin
                hold_d    = localData;
                pending_d = 1'b1;
            end
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            pending_q <= 1'b0;
            ovr_q     <= 16'd0;
            shift_q   <= '0;
            idx_q     <= '0;
            word_q    <= IDLE_WORD;
            k_q       <= IDLE_K;
            busy_q    <= 1'b0;
`ifdef LOCAL_PACKET_FRAMER_CRC_EN
            crc_q     <= CRC_INIT;
`endif
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            k_q       <= k_d;
            busy_q    <= busy_d;
`ifdef LOCAL_PACKET_FRAMER_CRC_EN
            crc_q     <= crc_d;
`endif
        end
    end

    assign txWord       = word_q;
    assign txCharIsK    = k_q;
    assign overrunCount = ovr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_local_packet_framer.sv
// Bench for local_packet_framer: directed scenarios plus random traffic,
// every cycle compared against a frame-queue reference model.
module tb_local_packet_framer;

    localparam int DW = 160;
    localparam int NW = DW / 16;

    logic          clk = 1'b0;
    logic          rstN;
    logic          txToggle;
    logic [DW-1:0] localData;
    logic [7:0]    nodeId;
    logic          txReady;
    logic [15:0]   txWord;
    logic [1:0]    txCharIsK;
    logic [15:0]   overrunCount;
    logic          busy;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // reference model state
    logic [17:0]   frm[$];
    logic          m_pend;
    logic [DW-1:0] m_buf;
    logic [15:0]   m_ovr;
    logic [15:0]   m_word;
    logic [1:0]    m_k;
    logic          m_busy;
    logic          m_tog;

    always #5 clk = ~clk;

    local_packet_framer #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .txToggle     (txToggle),
        .localData    (localData),
        .nodeId       (nodeId),
        .txReady      (txReady),
        .txWord       (txWord),
        .txCharIsK    (txCharIsK),
        .overrunCount (overrunCount),
        .busy         (busy)
    );

    function automatic logic [15:0] ref_crc(input logic [DW-1:0] p);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int b = DW - 1; b >= 0; b--) begin
            fb = c[15] ^ p[b];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    function automatic logic [DW-1:0] rand_payload();
        logic [DW-1:0] p;
        p = '0;
        for (int i = 0; i < DW / 32; i++) p = {p[DW-33:0], 32'($urandom())};
        return p;
    endfunction

    task automatic build_frame(input logic [DW-1:0] p);
        frm.push_back({2'b01, nodeId, 8'h3C});
        for (int i = 0; i < NW; i++) frm.push_back({2'b00, p[DW-1-16*i -: 16]});
`ifdef LOCAL_PACKET_FRAMER_CRC_EN
        frm.push_back({2'b00, ref_crc(p)});
`endif
    endtask

    task automatic model_reset();
        frm.delete();
        m_pend = 1'b0;
        m_buf  = '0;
        m_ovr  = 16'd0;
        m_word = 16'h50BC;
        m_k    = 2'b01;
        m_busy = 1'b0;
        m_tog  = txToggle;
    endtask

    // one clock edge of the framer, described as a word stream
    task automatic model_step();
        logic det, old, unl;
        logic [17:0] e;
        if (!rstN) begin
            model_reset();
            return;
        end
        det   = (txToggle != m_tog);
        m_tog = txToggle;
        old   = m_pend;
        unl   = 1'b0;
        if (txReady) begin
            if (frm.size() == 0 && m_pend) begin
                build_frame(m_buf);
                m_pend = 1'b0;
                unl    = 1'b1;
            end
            if (frm.size() > 0) begin
                e      = frm.pop_front();
                m_word = e[15:0];
                m_k    = e[17:16];
                m_busy = 1'b1;
            end else begin
                m_word = 16'h50BC;
                m_k    = 2'b01;
                m_busy = 1'b0;
            end
        end
        if (det) begin
            if (old && !unl) begin
                if (m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
            end else begin
                m_buf  = localData;
                m_pend = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check("txWord", txWord, m_word);
        check("txCharIsK", {14'd0, txCharIsK}, {14'd0, m_k});
        check("busy", {15'd0, busy}, {15'd0, m_busy});
        check("overrunCount", overrunCount, m_ovr);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic toggle(input logic [DW-1:0] d);
        localData = d;
        txToggle  = ~txToggle;
    endtask

    logic [DW-1:0] pay;
    logic [15:0]   held;

    initial begin
        // reset with txToggle high: only idle words afterwards
        rstN      = 1'b0;
        txToggle  = 1'b1;
        txReady   = 1'b1;
        nodeId    = 8'h07;
        localData = '0;
        model_reset();
        run(4);
        rstN = 1'b1;
        run(10);
        check("idle_after_reset", txWord, 16'h50BC);
        check("ovr_after_reset", overrunCount, 16'h0000);

        // known payload, node 7
        toggle(160'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF_9ABC_DEF0);
        run(2);
        check("sof_word", txWord, 16'h073C);
        check("sof_k", {14'd0, txCharIsK}, 16'h0001);
        run(1);
        check("data0", txWord, 16'h0123);
        run(16);
        check("idle_after_frame", txWord, 16'h50BC);

        // stall during the third data word
        pay = rand_payload();
        held = pay[DW-33 -: 16];
        toggle(pay);
        run(5);
        check("third_word", txWord, held);
        txReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold", txWord, held);
        end
        txReady = 1'b1;
        run(16);

        // three toggles two cycles apart: back-to-back, then one dropped
        toggle(rand_payload());
        run(2);
        toggle(rand_payload());
        run(2);
        toggle(rand_payload());
        run(40);
        check("overrun_one", overrunCount, 16'd1);

        // reset in the sixth data word, then a fresh frame
        toggle(rand_payload());
        run(8);
        rstN = 1'b0;
        model_reset();
        #1;
        check("rst_word", txWord, 16'h50BC);
        check("rst_busy", {15'd0, busy}, 16'd0);
        run(2);
        rstN = 1'b1;
        run(2);
        nodeId = 8'h5A;
        toggle(rand_payload());
        run(20);

        // dense back-to-back traffic with txReady high
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) toggle(rand_payload());
            tick();
        end

        // fully random traffic
        for (int i = 0; i < 400; i++) begin
            txReady = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) toggle(rand_payload());
            if ($urandom_range(0, 15) == 0) nodeId = 8'($urandom());
            if ($urandom_range(0, 149) == 0) begin
                rstN = 1'b0;
                model_reset();
                tick();
                rstN = 1'b1;
            end
            tick();
        end
        txReady = 1'b1;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/local_packet_framer.md
LOCAL_PACKET_FRAMER -- requirements
Module: local_packet_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 160; local payload width; a multiple of 16 and at least 16.
REQ-002 SHALL have parameter DEBUG, default "false"; mark_debug value on ports.
REQ-003 SHALL have clk  input  1  sole clock. There is one clock.
REQ-004 SHALL have rstN  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have txToggle  input  1  new-data toggle from the input handler.
REQ-006 SHALL have localData  input  DATA_WIDTH  payload; stable whenever txToggle is stable.
REQ-007 SHALL have nodeId  input  8  node number carried in the SOF word.
REQ-008 SHALL have txReady  input  1  transceiver accepts txWord on this edge.
REQ-009 SHALL have txWord  output  16  word to the transceiver.
REQ-010 SHALL have txCharIsK  output  2  K-character flags, one per byte of txWord.
REQ-011 SHALL have overrunCount  output  16  count of dropped payloads; saturating.
REQ-012 SHALL have busy  output  1  high while the FSM is in SOF, DATA or CRC.

Function
REQ-013 SHALL detect a new payload on any cycle where txToggle differs from its registered copy; all logic is in the clk domain.
REQ-014 SHALL capture localData into a one-entry hold buffer and set pending on the edge after detection.
REQ-015 SHALL, when a detection occurs while pending is already set, drop the new payload, keep the buffer unchanged and increment overrunCount, saturating at 16'hFFFF.
REQ-016 SHALL use FSM states IDLE, SOF, DATA and CRC.
REQ-017 SHALL, in IDLE, drive txWord=16'h50BC and txCharIsK=2'b01 (K28.5 followed by D16.2).
REQ-018 SHALL move from IDLE to SOF when pending is set and txReady=1; on that move it SHALL copy the buffer into a shift register and clear pending.
REQ-019 SHALL, in SOF, drive txWord={nodeId,8'h3C} and txCharIsK=2'b01.
REQ-020 SHALL, in DATA, drive DATA_WIDTH/16 words, most significant first, with txCharIsK=2'b00.
REQ-021 SHALL, in CRC, drive the CRC-16 word with txCharIsK=2'b00, then return to IDLE.
REQ-022 SHALL advance state or word index only on an edge where txReady=1; when txReady=0, txWord and txCharIsK SHALL hold unchanged.
REQ-023 SHALL register all outputs; the first SOF word appears no earlier than 2 cycles after the toggle change.
REQ-024 SHALL let a payload detected during SOF, DATA or CRC fill the buffer; that payload is sent back-to-back (CRC to SOF, no IDLE word) when txReady allows.
REQ-025 SHALL compute CRC-16 with polynomial 0x1021, init 0xFFFF, no reflection and no final XOR, over the data words only, MSB first.
REQ-026 SHALL treat a detection and a buffer unload on the same edge as a legal refill, with no overrun.
REQ-027 SHALL use a word index counter that wraps only through the CRC state and never exceeds DATA_WIDTH/16-1.

Reset
REQ-028 SHALL, while rstN=0, put the FSM in IDLE and set txWord=16'h50BC, txCharIsK=2'b01, overrunCount=0, busy=0 and pending=0.
REQ-029 SHALL, while rstN=0, load the registered toggle copy from txToggle so that no payload is detected at reset release.
REQ-030 SHALL, on reset mid-packet, abandon the packet; the frame is not resumed.

Configuration
REQ-031 SHALL, with LOCAL_PACKET_FRAMER_CRC_EN defined, include the CRC state and CRC logic; a frame is SOF, then data words, then CRC.
REQ-032 SHALL, without LOCAL_PACKET_FRAMER_CRC_EN, have no CRC state or logic; the FSM goes from DATA to IDLE, or to SOF if pending is set.

Structure
REQ-033 SHALL place these in a shared package (framer_pkg): the FSM state enum, IDLE_WORD, SOF_K (8'h3C), CRC_POLY and CRC_INIT.
REQ-034 SHALL implement the CRC in one sub-module, crc16_word: a 16-bit-per-cycle combinational next-CRC function instantiated once.

Verification
REQ-035 SHALL verify: rstN low then high with txToggle=1 -> idle words only, overrunCount=0.
REQ-036 SHALL verify: txReady=1, toggle with localData=160'h0123...DEF0 and nodeId=8'h07 -> 16'h073C/01, then 10 data words MS first, then the CRC matching a reference model, then 16'h50BC.
REQ-037 SHALL verify: txReady low for 5 cycles during the 3rd data word -> that word held for 5 cycles with no skip or duplicate after release.
REQ-038 SHALL verify: three toggles 2 cycles apart during a frame -> second payload sent back-to-back, third dropped, overrunCount=1.
REQ-039 SHALL verify: rstN asserted in the 6th data word -> next edge shows 16'h50BC/01 and busy=0; the next toggle gives a complete frame.
REQ-040 SHALL verify: build without LOCAL_PACKET_FRAMER_CRC_EN -> frame is 11 words and is followed directly by an idle word.
